// File: rtl/song_mem_axi_pkg.sv
// Shared constants, state types and small helpers for the song-sample memory AXI4 slave.
package song_mem_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    // Only full-word FIXED/INCR bursts are served; WRAP and the reserved encoding are rejected.
    function automatic logic burst_unsupported(logic [1:0] burst, logic [2:0] size);
        return (burst == BURST_WRAP) || (burst == 2'b11) || (size != 3'd2);
    endfunction

    function automatic logic idx_oor(int unsigned idx, int unsigned words);
        return idx >= words;
    endfunction

endpackage

// File: rtl/song_mem_axi4_slave_if.sv
// AXI4 bus bundle between the song-memory slave and its master; master/slave views.
interface song_mem_axi4_slave_if #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic [3:0]            awregion;
    logic                  awvalid;
    logic                  awready;

    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
        output awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        output arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
        input awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        input arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/song_mem_axi_addr_gen.sv
// Per-channel burst address tracker: holds the current word index, steps it per burst type
// and flags unsupported or out-of-range bursts.
module song_mem_axi_addr_gen
    import song_mem_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [7:0]            load_len,
    input  logic [1:0]            load_burst,
    input  logic [2:0]            load_size,
    output logic [ADDR_WIDTH-2:0] idx,
    output logic [ADDR_WIDTH-2:0] next_idx,
    output logic                  oor,
    output logic                  load_err,
    output logic                  burst_err
);

    logic [ADDR_WIDTH-2:0] idx_q;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic [ADDR_WIDTH-2:0] load_idx;
    logic [31:0]           load_last_idx;
    logic                  unused_lsb;

    // One spare index bit so an INCR burst running off the top reads as out of range, not word 0.
    assign load_idx   = {1'b0, load_addr[ADDR_WIDTH-1:2]};
    assign unused_lsb = ^load_addr[1:0];

    assign load_last_idx = 32'(load_idx) + ((load_burst == BURST_FIXED) ? 32'd0 : 32'(load_len));
    assign load_err      = burst_unsupported(load_burst, load_size) ||
                           idx_oor(load_last_idx, MEM_WORDS);

    assign next_idx  = (burst_q == BURST_FIXED) ? idx_q : idx_q + (ADDR_WIDTH-1)'(1);
    assign idx       = idx_q;
    assign oor       = idx_oor(32'(idx_q), MEM_WORDS);
    assign burst_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            burst_q <= BURST_INCR;
            err_q   <= 1'b0;
        end else if (load) begin
            idx_q   <= load_idx;
            burst_q <= load_burst;
            err_q   <= load_err;
        end else if (step) begin
            idx_q   <= next_idx;
        end
    end

endmodule

// File: rtl/song_mem_axi4_slave.sv
// AXI4 burst slave serving the song-sample word array; independent write and read channels,
// one outstanding burst each, one beat per cycle.
module song_mem_axi4_slave
    import song_mem_axi_pkg::*;
#(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 10,
    parameter int unsigned C_MEM_WORDS        = 256
) (
    input logic                  clk,
    input logic                  rst,
    song_mem_axi4_slave_if.slave s_axi
);

    localparam int unsigned IdxWidth    = C_S_AXI_ADDR_WIDTH - 1;
    localparam int unsigned MemIdxWidth = $clog2(C_MEM_WORDS);

    logic [31:0] mem [C_MEM_WORDS];

    w_state_e                    w_state;
    logic [7:0]                  w_cnt, w_len;
    logic                        w_err_q;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id_q;
    r_state_e                    r_state;
    logic [7:0]                  r_cnt, r_len;
    logic [C_S_AXI_ID_WIDTH-1:0] r_id_q;

    logic                aw_hs, w_hs, ar_hs, r_step;
    logic                w_last_beat, w_beat_err, mem_we;
    logic [IdxWidth-1:0] w_idx, w_next_idx, r_idx, r_next_idx, rd_idx;
    logic                w_oor, w_load_err, w_burst_err, r_oor, r_load_err, r_burst_err;
    logic                rd_oor;
    logic [31:0]         rd_word;
    logic                unused_ag;

    assign aw_hs  = s_axi.awvalid && s_axi.awready;
    assign w_hs   = s_axi.wvalid && s_axi.wready;
    assign ar_hs  = s_axi.arvalid && s_axi.arready;
    assign r_step = (r_state == RData) && s_axi.rready && !s_axi.rlast;

    song_mem_axi_addr_gen #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .MEM_WORDS  (C_MEM_WORDS)
    ) u_w_addr (
        .clk        (clk),
        .rst        (rst),
        .load       (aw_hs),
        .step       (w_hs),
        .load_addr  (s_axi.awaddr),
        .load_len   (s_axi.awlen),
        .load_burst (s_axi.awburst),
        .load_size  (s_axi.awsize),
        .idx        (w_idx),
        .next_idx   (w_next_idx),
        .oor        (w_oor),
        .load_err   (w_load_err),
        .burst_err  (w_burst_err)
    );

    song_mem_axi_addr_gen #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .MEM_WORDS  (C_MEM_WORDS)
    ) u_r_addr (
        .clk        (clk),
        .rst        (rst),
        .load       (ar_hs),
        .step       (r_step),
        .load_addr  (s_axi.araddr),
        .load_len   (s_axi.arlen),
        .load_burst (s_axi.arburst),
        .load_size  (s_axi.arsize),
        .idx        (r_idx),
        .next_idx   (r_next_idx),
        .oor        (r_oor),
        .load_err   (r_load_err),
        .burst_err  (r_burst_err)
    );

    assign unused_ag = ^{w_next_idx, r_idx, r_oor, r_burst_err};

    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_err  = w_oor || (s_axi.wlast != w_last_beat);
    assign mem_we      = w_hs && !w_burst_err && !w_oor;

    // Idle looks up the AR address so the first word is registered on the handshake itself.
    assign rd_idx  = (r_state == RIdle) ? {1'b0, s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2]} : r_next_idx;
    assign rd_oor  = idx_oor(32'(rd_idx), C_MEM_WORDS);
    assign rd_word = rd_oor ? '0 : mem[rd_idx[MemIdxWidth-1:0]];

    assign s_axi.bid = w_id_q;
    assign s_axi.rid = r_id_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[w_idx[MemIdxWidth-1:0]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= WIdle;
            w_cnt         <= '0;
            w_len         <= '0;
            w_err_q       <= 1'b0;
            w_id_q        <= '0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= RESP_OKAY;
        end else begin
            unique case (w_state)
                WIdle: begin
                    s_axi.awready <= 1'b1;
                    if (aw_hs) begin
                        s_axi.awready <= 1'b0;
                        s_axi.wready  <= 1'b1;
                        w_id_q        <= s_axi.awid;
                        w_len         <= s_axi.awlen;
                        w_cnt         <= '0;
                        w_err_q       <= 1'b0;
                        w_state       <= WData;
                    end
                end
                WData: begin
                    if (w_hs) begin
                        w_cnt <= w_cnt + 8'd1;
                        if (w_beat_err) begin
                            w_err_q <= 1'b1;
                        end
                        if (w_last_beat) begin
                            s_axi.wready <= 1'b0;
                            s_axi.bvalid <= 1'b1;
                            s_axi.bresp  <= (w_burst_err || w_err_q || w_beat_err) ?
                                            RESP_SLVERR : RESP_OKAY;
                            w_state      <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (s_axi.bready) begin
                        s_axi.bvalid  <= 1'b0;
                        s_axi.awready <= 1'b1;
                        w_state       <= WIdle;
                    end
                end
                default: w_state <= WIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RIdle;
            r_cnt         <= '0;
            r_len         <= '0;
            r_id_q        <= '0;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= RESP_OKAY;
            s_axi.rlast   <= 1'b0;
        end else begin
            unique case (r_state)
                RIdle: begin
                    s_axi.arready <= 1'b1;
                    if (ar_hs) begin
                        s_axi.arready <= 1'b0;
                        s_axi.rvalid  <= 1'b1;
                        s_axi.rdata   <= rd_word;
                        s_axi.rresp   <= r_load_err ? RESP_SLVERR : RESP_OKAY;
                        s_axi.rlast   <= (s_axi.arlen == 8'd0);
                        r_id_q        <= s_axi.arid;
                        r_len         <= s_axi.arlen;
                        r_cnt         <= '0;
                        r_state       <= RData;
                    end
                end
                RData: begin
                    if (s_axi.rready) begin
                        if (s_axi.rlast) begin
                            s_axi.rvalid  <= 1'b0;
                            s_axi.rlast   <= 1'b0;
                            s_axi.arready <= 1'b1;
                            r_state       <= RIdle;
                        end else begin
                            s_axi.rdata <= rd_word;
                            s_axi.rlast <= ((r_cnt + 8'd1) == r_len);
                            r_cnt       <= r_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= RIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_song_mem_axi4_slave.sv
// Directed bench for song_mem_axi4_slave: burst writes/reads, strobes, FIXED, range and
// protocol errors, read back-pressure and reset mid-burst.
module tb_song_mem_axi4_slave;
    import song_mem_axi_pkg::*;

    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] wd      [256];
    logic [3:0]  ws      [256];
    logic [31:0] exp_d   [256];
    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [1:0]  bresp;
    int          n;

    song_mem_axi4_slave_if #(.ID_WIDTH(1), .ADDR_WIDTH(10)) bus ();

    song_mem_axi4_slave #(
        .C_S_AXI_ID_WIDTH   (1),
        .C_S_AXI_ADDR_WIDTH (10),
        .C_MEM_WORDS        (256)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, 32'(bus.awready), 32'd0);
        check({tag, "_wready"},  32'(bus.wready),  32'd0);
        check({tag, "_bvalid"},  32'(bus.bvalid),  32'd0);
        check({tag, "_bresp"},   32'(bus.bresp),   32'd0);
        check({tag, "_bid"},     32'(bus.bid),     32'd0);
        check({tag, "_arready"}, 32'(bus.arready), 32'd0);
        check({tag, "_rvalid"},  32'(bus.rvalid),  32'd0);
        check({tag, "_rdata"},   bus.rdata,        32'd0);
        check({tag, "_rresp"},   32'(bus.rresp),   32'd0);
        check({tag, "_rlast"},   32'(bus.rlast),   32'd0);
        check({tag, "_rid"},     32'(bus.rid),     32'd0);
    endtask

    // Called at a falling edge; returns at a falling edge after the B handshake.
    task automatic do_write(input logic [9:0] addr, input int len, input logic [1:0] burst,
                            input int last_at, input logic id, output logic [1:0] resp);
        int k;
        bus.awaddr  = addr;
        bus.awlen   = 8'(len);
        bus.awburst = burst;
        bus.awsize  = 3'd2;
        bus.awid    = id;
        bus.awvalid = 1'b1;
        k = 0;
        while (!bus.awready && k < TMO) begin @(negedge clk); k++; end
        check("aw_ready", 32'(bus.awready), 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.wdata  = wd[i];
            bus.wstrb  = ws[i];
            bus.wlast  = (i == last_at);
            bus.wvalid = 1'b1;
            k = 0;
            while (!bus.wready && k < TMO) begin @(negedge clk); k++; end
            check("w_ready", 32'(bus.wready), 32'd1);
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        check("b_valid_timing", 32'(bus.bvalid), 32'd1);
        check("b_id", 32'(bus.bid), 32'(id));
        resp = bus.bresp;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] addr, input int len, input logic [1:0] burst,
                           input logic toggle, input logic id);
        int k;
        int cyc;
        bus.araddr  = addr;
        bus.arlen   = 8'(len);
        bus.arburst = burst;
        bus.arsize  = 3'd2;
        bus.arid    = id;
        bus.arvalid = 1'b1;
        bus.rready  = !toggle;
        k = 0;
        while (!bus.arready && k < TMO) begin @(negedge clk); k++; end
        check("ar_ready", 32'(bus.arready), 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("r_id", 32'(bus.rid), 32'(id));
        k   = 0;
        cyc = 0;
        while (k <= len && cyc < 4 * TMO) begin
            if (toggle) bus.rready = (cyc % 2 == 0);
            else check("r_valid_timing", 32'(bus.rvalid), 32'd1);
            if (bus.rvalid) begin
                if (bus.rready) begin
                    rd_data[k] = bus.rdata;
                    rd_resp[k] = bus.rresp;
                    rd_last[k] = bus.rlast;
                    k++;
                end else begin
                    check("r_stall_data", bus.rdata, exp_d[k]);
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.rready = 1'b0;
        check("r_beats", 32'(k), 32'(len + 1));
        check("r_done", 32'(bus.rvalid), 32'd0);
    endtask

    task automatic check_read(input string tag, input int len, input logic [1:0] resp);
        for (int i = 0; i <= len; i++) begin
            check({tag, "_data"}, rd_data[i], exp_d[i]);
            check({tag, "_last"}, 32'(rd_last[i]), 32'(i == len));
            check({tag, "_resp"}, 32'(rd_resp[i]), 32'(resp));
        end
    endtask

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = '0;
        bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0;
        bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = '0;
        bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_awready", 32'(bus.awready), 32'd1);
        check("post_reset_arready", 32'(bus.arready), 32'd1);

        // INCR 8-beat write then read back.
        for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; exp_d[i] = 32'(i + 1); end
        do_write(10'h000, 7, BURST_INCR, 7, 1'b1, bresp);
        check("incr_bresp", 32'(bresp), 32'(RESP_OKAY));
        do_read(10'h000, 7, BURST_INCR, 1'b0, 1'b1);
        check_read("incr_rd", 7, RESP_OKAY);

        // Byte strobes merge into an existing word.
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        do_write(10'h020, 0, BURST_INCR, 0, 1'b0, bresp);
        check("strb_full_bresp", 32'(bresp), 32'(RESP_OKAY));
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        do_write(10'h020, 0, BURST_INCR, 0, 1'b0, bresp);
        check("strb_part_bresp", 32'(bresp), 32'(RESP_OKAY));
        exp_d[0] = 32'hAA22CC44;
        do_read(10'h020, 0, BURST_INCR, 1'b0, 1'b0);
        check_read("strb_rd", 0, RESP_OKAY);

        // FIXED burst keeps hitting one word.
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        do_write(10'h044, 0, BURST_INCR, 0, 1'b0, bresp);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 5); ws[i] = 4'hF; end
        do_write(10'h040, 3, BURST_FIXED, 3, 1'b0, bresp);
        check("fixed_bresp", 32'(bresp), 32'(RESP_OKAY));
        exp_d[0] = 32'd8;
        do_read(10'h040, 0, BURST_INCR, 1'b0, 1'b0);
        check_read("fixed_rd40", 0, RESP_OKAY);
        exp_d[0] = 32'h12345678;
        do_read(10'h044, 0, BURST_INCR, 1'b0, 1'b0);
        check_read("fixed_rd44", 0, RESP_OKAY);

        // Burst running past the last word.
        wd[0] = 32'hDEAD0001; wd[1] = 32'hDEAD0002; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(10'h3F8, 1, BURST_INCR, 1, 1'b0, bresp);
        check("top_fill_bresp", 32'(bresp), 32'(RESP_OKAY));
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 9); ws[i] = 4'hF; end
        do_write(10'h3F8, 3, BURST_INCR, 3, 1'b0, bresp);
        check("oor_bresp", 32'(bresp), 32'(RESP_SLVERR));
        exp_d[0] = 32'hDEAD0001; exp_d[1] = 32'hDEAD0002;
        do_read(10'h3F8, 1, BURST_INCR, 1'b0, 1'b0);
        check_read("oor_unchanged", 1, RESP_OKAY);
        exp_d[2] = 32'd0; exp_d[3] = 32'd0;
        do_read(10'h3F8, 3, BURST_INCR, 1'b0, 1'b0);
        check_read("oor_rd", 3, RESP_SLVERR);

        // WRAP is rejected and writes nothing.
        wd[0] = 32'hBEEF0000; ws[0] = 4'hF;
        do_write(10'h080, 0, BURST_INCR, 0, 1'b0, bresp);
        wd[0] = 32'd1; wd[1] = 32'd2; ws[1] = 4'hF;
        do_write(10'h080, 1, BURST_WRAP, 1, 1'b0, bresp);
        check("wrap_bresp", 32'(bresp), 32'(RESP_SLVERR));
        exp_d[0] = 32'hBEEF0000;
        do_read(10'h080, 0, BURST_INCR, 1'b0, 1'b0);
        check_read("wrap_rd", 0, RESP_OKAY);

        // WLAST on the wrong beat: error response, burst still runs to its length.
        wd[0] = 32'h600D0000; wd[1] = 32'h600D0001; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(10'h060, 1, BURST_INCR, 0, 1'b0, bresp);
        check("wlast_bresp", 32'(bresp), 32'(RESP_SLVERR));
        check("wlast_next_aw", 32'(bus.awready), 32'd1);
        exp_d[0] = 32'h600D0000; exp_d[1] = 32'h600D0001;
        do_read(10'h060, 1, BURST_INCR, 1'b0, 1'b0);
        check_read("wlast_rd", 1, RESP_OKAY);

        // Read with RREADY toggling every cycle.
        for (int i = 0; i < 8; i++) exp_d[i] = 32'(i + 1);
        do_read(10'h000, 7, BURST_INCR, 1'b1, 1'b1);
        check_read("toggle_rd", 7, RESP_OKAY);

        // Reset during beat 4 of an 8-beat write.
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hCAFE0000 + 32'(i); ws[i] = 4'hF; end
        do_write(10'h100, 7, BURST_INCR, 7, 1'b0, bresp);
        bus.awaddr = 10'h100; bus.awlen = 8'd7; bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < TMO) begin @(negedge clk); n++; end
        check("mid_aw_ready", 32'(bus.awready), 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wdata = 32'h100 + 32'(i); bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
            n = 0;
            while (!bus.wready && n < TMO) begin @(negedge clk); n++; end
            check("mid_w_ready", 32'(bus.wready), 32'd1);
            @(negedge clk);
        end
        bus.wdata = 32'h103;
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        bus.wvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_awready", 32'(bus.awready), 32'd1);
        check("mid_rel_arready", 32'(bus.arready), 32'd1);
        check("mid_rel_wready", 32'(bus.wready), 32'd0);
        wd[0] = 32'h00000077; ws[0] = 4'hF;
        do_write(10'h200, 0, BURST_INCR, 0, 1'b1, bresp);
        check("after_rst_bresp", 32'(bresp), 32'(RESP_OKAY));
        for (int i = 0; i < 8; i++) exp_d[i] = (i < 3) ? 32'h100 + 32'(i) : 32'hCAFE0000 + 32'(i);
        do_read(10'h100, 7, BURST_INCR, 1'b0, 1'b0);
        check_read("after_rst_rd", 7, RESP_OKAY);
        exp_d[0] = 32'h00000077;
        do_read(10'h200, 0, BURST_INCR, 1'b0, 1'b1);
        check_read("after_rst_new", 0, RESP_OKAY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
